// File: rtl/pll_reset_sequencer.sv
// ----------------------------------------------------------------------------
// pll_reset_sequencer
//   Brings up a multi-output fabric PLL from its reference clock domain and
//   then releases the per-domain resets one at a time in index order. The PLL
//   is held in reset for a fixed time, then lock is awaited with a timeout.
//   Lock must then stay high for a qualification window. After that, domain
//   resets are released DOMAIN_GAP_CYCLES apart.
//   If lock is lost while domains are running or being released, everything
//   goes back into reset and the event is counted. Repeated lock timeouts
//   park the block in FAULT until a soft reset request arrives.
//
// Ports
//   refclk         in   PLL reference clock, the only clock of this block
//   rst            in   asynchronous active-high reset
//   pll_locked     in   raw PLL lock indicator (asynchronous)
//   soft_reset_req in   single-cycle request to restart the whole sequence
//   pll_rst        out  PLL reset, active-high
//   domain_rst     out  per-domain resets, bit i drives the outclk_i domain
//   all_ready      out  high only while every domain is out of reset (RUN)
//   fault          out  high only in FAULT
//   lock_lost_cnt  out  saturating count of lock-loss events
//   state_dbg      out  encoded FSM state
// ----------------------------------------------------------------------------
module pll_reset_sequencer #(
   parameter int NUM_DOMAINS         = 9,
   parameter int PLL_RST_CYCLES      = 64,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int DOMAIN_GAP_CYCLES   = 16,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRIES         = 3
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   pll_locked,
   input  logic                   soft_reset_req,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   all_ready,
   output logic                   fault,
   output logic [7:0]             lock_lost_cnt,
   output logic [2:0]             state_dbg
);

   // One shared timer serves PLL_RESET, WAIT_LOCK and LOCK_STABLE, so it is
   // sized for the largest of the three windows.
   localparam int TMR_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int TMR_MAX   = (TMR_MAX_A > LOCK_TIMEOUT_CYCLES) ? TMR_MAX_A : LOCK_TIMEOUT_CYCLES;
   localparam int TMR_W     = $clog2(TMR_MAX + 1);
   localparam int GAP_W     = $clog2(DOMAIN_GAP_CYCLES + 1);
   localparam int IDX_W     = $clog2(NUM_DOMAINS + 1);
   localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {
      ST_PLL_RESET   = 3'd0,
      ST_WAIT_LOCK   = 3'd1,
      ST_LOCK_STABLE = 3'd2,
      ST_RELEASE     = 3'd3,
      ST_RUN         = 3'd4,
      ST_FAULT       = 3'd5
   } state_t;

   // Saturating 8-bit increment for the lock-loss counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   state_t                 state_r, state_s;
   logic [TMR_W-1:0]       timer_r, timer_s;
   logic [GAP_W-1:0]       gap_r, gap_s;
   logic [IDX_W-1:0]       idx_r, idx_s;
   logic [RETRY_W-1:0]     retry_r, retry_s;
   logic                   locked_meta_r, locked_sync_r;
   logic                   pll_rst_r, pll_rst_s;
   logic [NUM_DOMAINS-1:0] domain_rst_r, domain_rst_s;
   logic                   all_ready_r, all_ready_s;
   logic                   fault_r, fault_s;
   logic [7:0]             lost_cnt_r, lost_cnt_s;
   logic                   lock_lost_s;

   // Two-flop synchronizer for the asynchronous lock indicator.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         locked_meta_r <= 1'b0;
         locked_sync_r <= 1'b0;
      end else begin
         locked_meta_r <= pll_locked;
         locked_sync_r <= locked_meta_r;
      end
   end

   // FSM state, counters and registered outputs.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_PLL_RESET;
         timer_r      <= '0;
         gap_r        <= '0;
         idx_r        <= '0;
         retry_r      <= '0;
         pll_rst_r    <= 1'b1;
         domain_rst_r <= '1;
         all_ready_r  <= 1'b0;
         fault_r      <= 1'b0;
         lost_cnt_r   <= 8'd0;
      end else begin
         state_r      <= state_s;
         timer_r      <= timer_s;
         gap_r        <= gap_s;
         idx_r        <= idx_s;
         retry_r      <= retry_s;
         pll_rst_r    <= pll_rst_s;
         domain_rst_r <= domain_rst_s;
         all_ready_r  <= all_ready_s;
         fault_r      <= fault_s;
         lost_cnt_r   <= lost_cnt_s;
      end
   end

   // Next-state, counter and output decode. Outputs are derived from the
   // next state so the registered outputs always agree with state_r.
   always_comb begin
      state_s      = state_r;
      timer_s      = timer_r;
      gap_s        = gap_r;
      idx_s        = idx_r;
      retry_s      = retry_r;
      domain_rst_s = domain_rst_r;
      lost_cnt_s   = lost_cnt_r;
      pll_rst_s    = 1'b1;
      all_ready_s  = 1'b0;
      fault_s      = 1'b0;

      // Lock loss only matters once domains have started coming out of reset.
      lock_lost_s = !locked_sync_r && ((state_r == ST_RELEASE) || (state_r == ST_RUN));

      case (state_r)
         ST_PLL_RESET: begin
            if (timer_r == TMR_W'(PLL_RST_CYCLES - 1)) begin
               state_s = ST_WAIT_LOCK;
               timer_s = '0;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_WAIT_LOCK: begin
            if (locked_sync_r) begin
               state_s = ST_LOCK_STABLE;
               timer_s = '0;
            end else if (timer_r == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
               timer_s = '0;
               retry_s = retry_r + RETRY_W'(1);
               if (retry_r == RETRY_W'(MAX_RETRIES - 1)) begin
                  state_s = ST_FAULT;
               end else begin
                  state_s = ST_PLL_RESET;
               end
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_LOCK_STABLE: begin
            if (!locked_sync_r) begin
               state_s = ST_WAIT_LOCK;
               timer_s = '0;
            end else if (timer_r == TMR_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_s = ST_RELEASE;
               timer_s = '0;
               retry_s = '0;
               idx_s   = '0;
               gap_s   = '0;
            end else begin
               timer_s = timer_r + TMR_W'(1);
            end
         end
         ST_RELEASE: begin
            if (gap_r == GAP_W'(DOMAIN_GAP_CYCLES - 1)) begin
               gap_s        = '0;
               idx_s        = idx_r + IDX_W'(1);
               domain_rst_s = domain_rst_r & ~(NUM_DOMAINS'(1) << idx_r);
               if (idx_r == IDX_W'(NUM_DOMAINS - 1)) begin
                  state_s = ST_RUN;
               end else begin
                  state_s = ST_RELEASE;
               end
            end else begin
               gap_s = gap_r + GAP_W'(1);
            end
         end
         ST_RUN: begin
            state_s = ST_RUN;
         end
         ST_FAULT: begin
            state_s = ST_FAULT;
         end
         default: begin
            state_s = ST_PLL_RESET;
            timer_s = '0;
         end
      endcase

      // Lock loss and soft reset both abort to PLL_RESET; lock loss takes
      // precedence so a coincident request still gets counted exactly once.
      if (lock_lost_s || soft_reset_req) begin
         state_s = ST_PLL_RESET;
         timer_s = '0;
         retry_s = '0;
         gap_s   = '0;
         idx_s   = '0;
         if (lock_lost_s) begin
            lost_cnt_s = sat_inc8(lost_cnt_r);
         end else begin
            lost_cnt_s = lost_cnt_r;
         end
      end else begin
         lost_cnt_s = lost_cnt_r;
      end

      // Domain resets: all asserted outside RELEASE/RUN, all clear in RUN.
      if (state_s == ST_RUN) begin
         domain_rst_s = '0;
      end else if (state_s != ST_RELEASE) begin
         domain_rst_s = '1;
      end else begin
         domain_rst_s = domain_rst_s;
      end

      pll_rst_s   = (state_s == ST_PLL_RESET) || (state_s == ST_FAULT);
      all_ready_s = (state_s == ST_RUN);
      fault_s     = (state_s == ST_FAULT);
   end

   assign pll_rst       = pll_rst_r;
   assign domain_rst    = domain_rst_r;
   assign all_ready     = all_ready_r;
   assign fault         = fault_r;
   assign lock_lost_cnt = lost_cnt_r;
   assign state_dbg     = state_r;

endmodule
